// File: rtl/capture_sequencer_pkg.sv
// Shared constants for the phase-capture sequencer: top/dump state codes,
// pre-trigger depth derivation and the byte order used on the UART stream.
package capture_pkg;

    // Top-level capture states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_POST = 2'd2;
    localparam logic [1:0] ST_DUMP = 2'd3;

    // Dump sub-states (one 16-bit word -> two UART bytes)
    localparam logic [2:0] DS_RD  = 3'd0;
    localparam logic [2:0] DS_LO  = 3'd1;
    localparam logic [2:0] DS_LOW = 3'd2;
    localparam logic [2:0] DS_HI  = 3'd3;
    localparam logic [2:0] DS_HIW = 3'd4;

    // Words are sent little-endian: low byte first
    localparam bit LSB_FIRST = 1'b1;

    // Number of pre-trigger words kept in a 2^aw deep ring
    function automatic int pre_depth(input int aw, input int post);
        return (1 << aw) - post;
    endfunction

endpackage

// File: rtl/capture_sequencer_word_byte_tx.sv
// Serialises one 16-bit RAM word into two UART bytes.
//
// Handshake with acia_tx: tx_start is a one-cycle pulse issued only in a cycle
// after tx_busy was sampled low; the cycle following each pulse is a guard
// cycle in which tx_busy is ignored (the UART raises busy one cycle late), then
// the next byte waits for tx_busy low again. This gives at most one pulse per
// busy-low window and never two pulses back to back.
module word_byte_tx
    import capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        last,
    input  logic [15:0] word,
    input  logic        tx_busy,
    output logic [7:0]  tx_dat,
    output logic        tx_start,
    output logic        done,
    output logic        word_done,
    output logic [2:0]  sub_state
);

    logic [2:0] state;
    logic       guard;
    logic [7:0] second_byte;
    logic [7:0] first_byte;
    logic [7:0] other_byte;

    assign first_byte = LSB_FIRST ? word[7:0]  : word[15:8];
    assign other_byte = LSB_FIRST ? word[15:8] : word[7:0];
    assign sub_state  = state;

    // Second byte is being launched this cycle: the word is consumed
    assign word_done = run && (state == DS_HI) && !tx_busy;

    // Byte sequencer: RD -> LO -> LOW -> HI -> HIW -> RD
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DS_RD;
            guard       <= 1'b0;
            second_byte <= 8'd0;
            tx_dat      <= 8'd0;
            tx_start    <= 1'b0;
            done        <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (!run) begin
                state <= DS_RD;
                guard <= 1'b0;
            end else begin
                case (state)
                    DS_RD: state <= DS_LO;
                    DS_LO: begin
                        if (!tx_busy) begin
                            tx_start    <= 1'b1;
                            tx_dat      <= first_byte;
                            second_byte <= other_byte;
                            guard       <= 1'b1;
                            state       <= DS_LOW;
                        end
                    end
                    DS_LOW: begin
                        if (guard)         guard <= 1'b0;
                        else if (!tx_busy) state <= DS_HI;
                    end
                    DS_HI: begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            tx_dat   <= second_byte;
                            done     <= last;
                            guard    <= 1'b1;
                            state    <= DS_HIW;
                        end
                    end
                    DS_HIW: begin
                        if (guard)         guard <= 1'b0;
                        else if (!tx_busy) state <= DS_RD;
                    end
                    default: state <= DS_RD;
                endcase
            end
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Phase-capture controller: fills a circular RAM with pre-trigger history,
// records a fixed post-trigger window, then streams the buffer oldest word
// first to the UART through word_byte_tx.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int POST = 192
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          trig,
    input  logic          sample_stb,
    input  logic [DW-1:0] sample,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [7:0]    tx_dat,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam logic [AW-1:0] PRE_FILL  = AW'(pre_depth(AW, POST));
    localparam logic [AW-1:0] POST_LAST = AW'(POST - 1);

    logic [1:0]    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] fill;
    logic [AW-1:0] postcnt;
    logic [AW-1:0] wcnt;
    logic          trig_q;
    logic          trig_edge;
    logic          word_done;
    logic          dump_run;
    logic [2:0]    dump_sub_state;

    assign trig_edge = trig && !trig_q;
    assign dump_run  = (state == ST_DUMP);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Capture FSM, ring pointers and registered RAM write/read ports
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            fill      <= '0;
            postcnt   <= '0;
            wcnt      <= '0;
            trig_q    <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_raddr <= '0;
        end else begin
            trig_q <= trig;
            ram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state   <= ST_PRE;
                        wptr    <= '0;
                        fill    <= '0;
                        postcnt <= '0;
                    end
                end
                ST_PRE: begin
                    if (arm) begin
                        wptr    <= '0;
                        fill    <= '0;
                        postcnt <= '0;
                    end else begin
                        if (sample_stb) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= wptr;
                            ram_wdata <= sample;
                            wptr      <= wptr + AW'(1);
                            if (fill != PRE_FILL) fill <= fill + AW'(1);
                        end
                        // fill is the count before this cycle's write
                        if (trig_edge && fill == PRE_FILL) begin
                            state   <= ST_POST;
                            postcnt <= '0;
                        end
                    end
                end
                ST_POST: begin
                    if (arm) begin
                        state   <= ST_PRE;
                        wptr    <= '0;
                        fill    <= '0;
                        postcnt <= '0;
                    end else if (sample_stb) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= wptr;
                        ram_wdata <= sample;
                        wptr      <= wptr + AW'(1);
                        postcnt   <= postcnt + AW'(1);
                        if (postcnt == POST_LAST) begin
                            // Slot after the last write holds the oldest word
                            state     <= ST_DUMP;
                            ram_raddr <= wptr + AW'(1);
                            wcnt      <= '0;
                        end
                    end
                end
                ST_DUMP: begin
                    if (word_done) begin
                        ram_raddr <= ram_raddr + AW'(1);
                        wcnt      <= wcnt + AW'(1);
                        if (&wcnt) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    word_byte_tx u_word_byte_tx (
        .clk       (clk),
        .rst       (rst),
        .run       (dump_run),
        .last      (&wcnt),
        .word      (ram_rdata[15:0]),
        .tx_busy   (tx_busy),
        .tx_dat    (tx_dat),
        .tx_start  (tx_start),
        .done      (done),
        .word_done (word_done),
        .sub_state (dump_sub_state)
    );

    logic unused_ok;
    assign unused_ok = ^dump_sub_state;

endmodule
